// File: rtl/sentinel_wb_arbiter.sv
// sentinel_wb_arbiter: two-master round-robin Wishbone classic arbiter; optional watchdog via SENTINEL_WB_ARB_WATCHDOG_EN
module sentinel_wb_arbiter #(
    parameter int TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0__cyc,
    input  logic        m0__stb,
    input  logic        m0__we,
    input  logic [29:0] m0__adr,
    input  logic [3:0]  m0__sel,
    input  logic [31:0] m0__dat_w,
    output logic        m0__ack,
    output logic [31:0] m0__dat_r,
    input  logic        m1__cyc,
    input  logic        m1__stb,
    input  logic        m1__we,
    input  logic [29:0] m1__adr,
    input  logic [3:0]  m1__sel,
    input  logic [31:0] m1__dat_w,
    output logic        m1__ack,
    output logic [31:0] m1__dat_r,
    output logic        s__cyc,
    output logic        s__stb,
    output logic        s__we,
    output logic [29:0] s__adr,
    output logic [3:0]  s__sel,
    output logic [31:0] s__dat_w,
    input  logic        s__ack,
    input  logic [31:0] s__dat_r,
    output logic [1:0]  grant,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, state_n;
    logic last, last_n;
    logic own0, own1, mstb, fire;
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..255");
    end
    assign own0 = state == OWN0;
    assign own1 = state == OWN1;
    assign mstb = own0 ? m0__stb : own1 ? m1__stb : 1'b0;
`ifdef SENTINEL_WB_ARB_WATCHDOG_EN
    logic [7:0] cnt;
    logic mcyc;
    assign mcyc = own0 ? m0__cyc : own1 ? m1__cyc : 1'b0;
    assign fire = mstb && !s__ack && cnt == 8'(TIMEOUT);
    assign timeout = fire;
    // count stalled strobe cycles of the current owner; any ack, idle strobe, release or firing clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= (mcyc && mstb && !s__ack && !fire) ? cnt + 8'd1 : '0;
    end
`else
    assign fire = 1'b0;
    assign timeout = 1'b0;
`endif
    // ownership and round-robin history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
        end else begin
            state <= state_n;
            last <= last_n;
        end
    end
    // arbitration: a tie goes to the master that did not own the bus last; release always passes through IDLE
    always_comb begin
        state_n = state;
        last_n = last;
        case (state)
            IDLE: state_n = (m0__cyc && m1__cyc) ? (last ? OWN0 : OWN1) :
                            m0__cyc ? OWN0 : m1__cyc ? OWN1 : IDLE;
            OWN0: if (!m0__cyc) begin
                state_n = IDLE;
                last_n = 1'b0;
            end
            OWN1: if (!m1__cyc) begin
                state_n = IDLE;
                last_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // combinational request mux to the slave and response steering back to the owner
    always_comb begin
        grant = {own1, own0};
        s__cyc = own0 ? m0__cyc : own1 ? m1__cyc : 1'b0;
        s__stb = mstb && !fire;
        s__we = own0 ? m0__we : own1 ? m1__we : 1'b0;
        s__adr = own0 ? m0__adr : own1 ? m1__adr : '0;
        s__sel = own0 ? m0__sel : own1 ? m1__sel : '0;
        s__dat_w = own0 ? m0__dat_w : own1 ? m1__dat_w : '0;
        m0__ack = own0 && (s__ack || fire);
        m1__ack = own1 && (s__ack || fire);
        m0__dat_r = rst ? '0 : (own0 && fire) ? '1 : s__dat_r;
        m1__dat_r = rst ? '0 : (own1 && fire) ? '1 : s__dat_r;
    end
endmodule

// File: doc/sentinel_wb_arbiter.md
# sentinel_wb_arbiter

Two-master Wishbone classic arbiter that shares a single slave bus between the Sentinel core (master 0) and a secondary master (master 1: DMA or debug). Arbitration is round-robin; ownership is held for the whole of the winning master's `cyc` assertion. An optional bus watchdog terminates stalled slave cycles, so a hung peripheral cannot lock up the core.

## Interface
Parameters:
- `TIMEOUT`, default 7: number of wait-state cycles tolerated before the watchdog terminates a cycle. Legal range is 2..255.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `m0__cyc`, `m0__stb`, `m0__we`  in  1 each: master 0 request.
- `m0__adr`  in  30, `m0__sel`  in  4, `m0__dat_w`  in  32: master 0 address, byte select and write data.
- `m0__ack`  out  1, `m0__dat_r`  out  32: master 0 response.
- `m1__*`: identical port set for master 1.
- `s__cyc`, `s__stb`, `s__we`  out  1 each; `s__adr`  out  30; `s__sel`  out  4; `s__dat_w`  out  32: slave request.
- `s__ack`  in  1, `s__dat_r`  in  32: slave response.
- `grant`  out  2: one-hot owner (01 = m0, 10 = m1, 00 = idle).
- `timeout`  out  1: one-cycle pulse when the watchdog fires.

## Operation
- State machine has three states: IDLE, OWN0, OWN1. Register `last` records the most recent owner.
- IDLE:
  - Only `m0__cyc` high -> OWN0.
  - Only `m1__cyc` high -> OWN1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
- OWNn:
  - Slave outputs are a combinational mux of master n's request.
  - `s__ack` is routed to `mn__ack` only. The other master's `ack` is 0.
  - The state is held while `mn__cyc` is high, independent of `stb` (multiple transfers and RMW sequences are allowed).
- OWNn with `mn__cyc` low -> IDLE, and `last` <= n. No direct OWN0<->OWN1 hop; there is at least one IDLE cycle between owners.
- In IDLE, all `s__*` request outputs are 0.
- `m0__dat_r` and `m1__dat_r` both carry `s__dat_r`, except during a watchdog termination (see Configuration).
- `grant` is decoded directly from state.
- Reset (async, any time, including mid-cycle):
  - State -> IDLE, `last` -> 1 (m0 wins the first tie), watchdog counter -> 0.
  - All outputs -> 0.
  - A transfer in flight is abandoned. The master must re-request.

## Timing
- Arbitration latency: a `cyc` rising edge seen in IDLE produces the grant on the next `clk` edge. Slave `cyc`/`stb` appear 1 cycle after the master's `cyc` in the uncontended case.
- Once granted, the request path is combinational (0 cycles) and so is the `ack`/`dat_r` return path.
- A master dropping `cyc` on the same cycle as `s__ack` completes its transfer normally. The state is IDLE on the following cycle.
- `m1__cyc` rising while m0 owns the bus: m1 waits for m0's release plus 1 IDLE cycle, then OWN1.
- Both masters hold `cyc` continuously: ownership alternates per release (round-robin). Neither master starves.

## Configuration
- Macro: `SENTINEL_WB_ARB_WATCHDOG_EN`.
- Defined:
  - An 8-bit counter increments each cycle the owner has `s__stb` high and `s__ack` low.
  - The counter clears on `s__ack`, on `stb` low, or on leaving OWNn.
  - When the counter reaches `TIMEOUT`, that cycle:
    - the arbiter drives `mn__ack`=1 and `mn__dat_r`=32'hFFFF_FFFF;
    - `s__stb` is forced to 0;
    - `timeout` pulses 1.
  - If `s__ack` arrives on the same cycle the count reaches `TIMEOUT`, the slave ack wins: real data is returned and there is no `timeout` pulse.
  - A write that times out is reported as acked; the write is lost silently apart from `timeout`.
- Undefined: no counter is built, `timeout` is tied to 0, and stalled cycles wait indefinitely.

## Test plan
- Reset release with m0 reading 0x100 and slave ack after 2 wait states, `s__dat_r`=0xDEADBEEF -> `grant`=01 one cycle after `cyc`; `m0__ack` high 1 cycle with 0xDEADBEEF; `m1__ack` stays 0.
- `m0__cyc` and `m1__cyc` rise together from reset -> m0 granted first. After m0 drops `cyc`: 1 IDLE cycle, then `grant`=10.
- Both masters hold `cyc` and each releases after 1 transfer, over 6 transfers -> grant order m0,m1,m0,m1,m0,m1 with one IDLE cycle between each.
- m1 owns the bus, `rst` asserted mid-wait-state -> all outputs 0 asynchronously. After release, `grant`=00 until a new `cyc`.
- With the macro defined and `TIMEOUT`=7, m0 reads a slave that never acks -> after 7 stalled cycles: `m0__ack`=1, `dat_r`=0xFFFF_FFFF, `timeout`=1 for 1 cycle, `s__stb`=0.
- With the macro defined, `s__ack` on the exact timeout cycle -> slave data returned, `timeout`=0. With the macro undefined, the same stimulus keeps `m0__ack`=0 for 100 cycles.
